// File: rtl/render_core.sv
// Frame-rendering core: 1bpp double-buffered frame store, back-bank clear engine
// and the per-frame sequencer (clear, draw text row, run plot logic, wait swap).
module render_core #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int CHAR_WIDTH        = 16,
  parameter int TEXT_Y            = 0,
  parameter int X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
  parameter int Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS),
  parameter int PIXELS_COUNT      = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS,
  parameter int ADDR_WIDTH        = $clog2(PIXELS_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  swap,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  read_data,
  input  logic                  ext_write_enable,
  input  logic [ADDR_WIDTH-1:0] ext_write_addr,
  input  logic                  ext_write_data,
  output logic                  visible_iter_en,
  input  logic [6:0]            symbol,
  input  logic                  symbol_valid,
  output logic                  symbol_drawer_start,
  input  logic                  symbol_drawer_ready,
  output logic [X_WIDTH-1:0]    symbol_drawer_x,
  output logic [Y_WIDTH-1:0]    symbol_drawer_y,
  output logic                  logic_start,
  input  logic                  logic_ready,
  output logic                  frame_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(PIXELS_COUNT - 1);
  localparam logic [X_WIDTH-1:0]    CHAR_X     = X_WIDTH'(CHAR_WIDTH);
  localparam logic [X_WIDTH-1:0]    MAX_COL    = X_WIDTH'(HOR_ACTIVE_PIXELS / CHAR_WIDTH - 1);
  localparam logic [Y_WIDTH-1:0]    TEXT_Y_POS = Y_WIDTH'(TEXT_Y);

  typedef enum logic [3:0] {
    S_FILL, S_WAIT_FILL, S_FETCH, S_CHECK, S_DRAW,
    S_WAIT_SYM, S_LOGIC, S_WAIT_LOGIC, S_WAIT_SWAP
  } state_t;

  state_t                  state_r;
  logic                    front_sel_r;
  logic                    fill_start_r;
  logic                    fill_busy_r;
  logic [ADDR_WIDTH-1:0]   fill_addr_r;
  logic                    fill_ready_s;
  logic                    wait_r;
  logic [X_WIDTH-1:0]      col_r;
  logic                    row_full_r;
  logic                    wr_en_s;
  logic [ADDR_WIDTH-1:0]   wr_addr_s;
  logic                    wr_data_s;
  logic                    unused_s;

  logic bank0 [PIXELS_COUNT];
  logic bank1 [PIXELS_COUNT];

  // The symbol code is consumed by the symbol drawer, not by this core.
  assign unused_s = ^symbol;

  // Fill engine status and merged write port (idle fill drives all zeros).
  always_comb begin
    fill_ready_s = ~fill_busy_r;
    wr_en_s      = fill_busy_r | ext_write_enable;
    wr_addr_s    = fill_addr_r | ext_write_addr;
    wr_data_s    = 1'b0 | ext_write_data;
  end

  // Fill engine: sweeps every address once with data 0, then returns idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_busy_r <= 1'b0;
      fill_addr_r <= '0;
    end else if (fill_busy_r) begin
      if (fill_addr_r == LAST_ADDR) begin
        fill_busy_r <= 1'b0;
        fill_addr_r <= '0;
      end else begin
        fill_addr_r <= fill_addr_r + ADDR_WIDTH'(1);
      end
    end else if (fill_start_r) begin
      fill_busy_r <= 1'b1;
      fill_addr_r <= '0;
    end
  end

  // Bank select; swap is honoured in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_sel_r <= 1'b0;
    end else if (swap) begin
      front_sel_r <= ~front_sel_r;
    end
  end

  // Back-bank write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      if (front_sel_r) begin
        bank0[wr_addr_s] <= wr_data_s;
      end else begin
        bank1[wr_addr_s] <= wr_data_s;
      end
    end
  end

  // Front-bank registered read, one cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data <= 1'b0;
    end else if (front_sel_r) begin
      read_data <= bank1[read_addr];
    end else begin
      read_data <= bank0[read_addr];
    end
  end

  // Frame sequencer with registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r             <= S_FILL;
      fill_start_r        <= 1'b0;
      visible_iter_en     <= 1'b0;
      symbol_drawer_start <= 1'b0;
      symbol_drawer_x     <= '0;
      symbol_drawer_y     <= '0;
      logic_start         <= 1'b0;
      frame_done          <= 1'b0;
      wait_r              <= 1'b0;
      col_r               <= '0;
      row_full_r          <= 1'b0;
    end else begin
      fill_start_r        <= 1'b0;
      visible_iter_en     <= 1'b0;
      symbol_drawer_start <= 1'b0;
      logic_start         <= 1'b0;
      case (state_r)
        S_FILL: begin
          fill_start_r <= 1'b1;
          frame_done   <= 1'b0;
          state_r      <= S_WAIT_FILL;
        end
        // The engine reports ready until it has seen its own start pulse.
        S_WAIT_FILL: begin
          if (fill_ready_s && !fill_start_r) begin
            col_r      <= '0;
            row_full_r <= 1'b0;
            state_r    <= S_FETCH;
          end
        end
        S_FETCH: begin
          visible_iter_en <= 1'b1;
          wait_r          <= 1'b1;
          state_r         <= S_CHECK;
        end
        S_CHECK: begin
          if (wait_r) begin
            wait_r <= 1'b0;
          end else if (symbol_valid) begin
            state_r <= S_DRAW;
          end else begin
            state_r <= S_LOGIC;
          end
        end
        S_DRAW: begin
          if (row_full_r) begin
            state_r <= S_FETCH;
          end else begin
            symbol_drawer_start <= 1'b1;
            symbol_drawer_x     <= col_r * CHAR_X;
            symbol_drawer_y     <= TEXT_Y_POS;
            wait_r              <= 1'b1;
            state_r             <= S_WAIT_SYM;
          end
        end
        S_WAIT_SYM: begin
          if (wait_r) begin
            wait_r <= 1'b0;
          end else if (symbol_drawer_ready) begin
            if (col_r == MAX_COL) begin
              row_full_r <= 1'b1;
            end else begin
              col_r <= col_r + X_WIDTH'(1);
            end
            state_r <= S_FETCH;
          end
        end
        S_LOGIC: begin
          logic_start <= 1'b1;
          wait_r      <= 1'b1;
          state_r     <= S_WAIT_LOGIC;
        end
        S_WAIT_LOGIC: begin
          if (wait_r) begin
            wait_r <= 1'b0;
          end else if (logic_ready) begin
            frame_done <= 1'b1;
            state_r    <= S_WAIT_SWAP;
          end
        end
        S_WAIT_SWAP: begin
          if (swap) begin
            frame_done <= 1'b0;
            state_r    <= S_FILL;
          end
        end
        default: begin
          frame_done <= 1'b0;
          wait_r     <= 1'b0;
          state_r    <= S_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_render_core.sv
// Directed bench for render_core on a reduced 64x8 frame so full fills stay short;
// text buffer and symbol drawer are small behavioural stubs.
module tb_render_core;
  localparam int H  = 64;
  localparam int V  = 8;
  localparam int CW = 16;
  localparam int TY = 0;
  localparam int XW = 6;
  localparam int YW = 3;
  localparam int P  = 512;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          swap;
  logic [AW-1:0] read_addr;
  logic          read_data;
  logic          ext_write_enable;
  logic [AW-1:0] ext_write_addr;
  logic          ext_write_data;
  logic          visible_iter_en;
  logic [6:0]    symbol;
  logic          symbol_valid;
  logic          symbol_drawer_start;
  logic          symbol_drawer_ready;
  logic [XW-1:0] symbol_drawer_x;
  logic [YW-1:0] symbol_drawer_y;
  logic          logic_start;
  logic          logic_ready;
  logic          frame_done;

  always #5 clk = ~clk;

  render_core #(
    .HOR_ACTIVE_PIXELS(H), .VER_ACTIVE_PIXELS(V), .CHAR_WIDTH(CW), .TEXT_Y(TY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .swap(swap),
    .read_addr(read_addr), .read_data(read_data),
    .ext_write_enable(ext_write_enable), .ext_write_addr(ext_write_addr),
    .ext_write_data(ext_write_data),
    .visible_iter_en(visible_iter_en), .symbol(symbol), .symbol_valid(symbol_valid),
    .symbol_drawer_start(symbol_drawer_start), .symbol_drawer_ready(symbol_drawer_ready),
    .symbol_drawer_x(symbol_drawer_x), .symbol_drawer_y(symbol_drawer_y),
    .logic_start(logic_start), .logic_ready(logic_ready), .frame_done(frame_done)
  );

  // Text buffer stub: each iter pulse presents the next listed symbol.
  logic [6:0] text_list [8];
  int         text_n;
  int         text_idx;
  logic       text_rst;
  always @(posedge clk) begin
    if (text_rst) begin
      text_idx     <= 0;
      symbol       <= 7'd0;
      symbol_valid <= 1'b0;
    end else if (visible_iter_en) begin
      if (text_idx < text_n) begin
        symbol       <= text_list[text_idx];
        symbol_valid <= 1'b1;
        text_idx     <= text_idx + 1;
      end else begin
        symbol       <= 7'd0;
        symbol_valid <= 1'b0;
      end
    end
  end

  // Symbol drawer stub: busy for three cycles after each start.
  int dcnt = 0;
  always @(posedge clk) begin
    if (symbol_drawer_start) dcnt <= 3;
    else if (dcnt != 0) dcnt <= dcnt - 1;
  end
  assign symbol_drawer_ready = (dcnt == 0);

  // Pulse monitor: counts pulses, records drawer coordinates, flags wide pulses.
  logic          mon_clr;
  int            n_iter, n_sym, n_logic;
  int            n_wide = 0;
  logic [XW-1:0] xs [8];
  logic [YW-1:0] ys [8];
  logic          p_iter = 1'b0, p_sym = 1'b0, p_logic = 1'b0;
  always @(posedge clk) begin
    if (mon_clr) begin
      n_iter <= 0; n_sym <= 0; n_logic <= 0;
    end else begin
      if (visible_iter_en) n_iter <= n_iter + 1;
      if (logic_start) n_logic <= n_logic + 1;
      if (symbol_drawer_start) begin
        if (n_sym < 8) begin
          xs[n_sym] <= symbol_drawer_x;
          ys[n_sym] <= symbol_drawer_y;
        end
        n_sym <= n_sym + 1;
      end
    end
    if ((visible_iter_en && p_iter) || (symbol_drawer_start && p_sym) || (logic_start && p_logic))
      n_wide <= n_wide + 1;
    p_iter  <= visible_iter_en;
    p_sym   <= symbol_drawer_start;
    p_logic <= logic_start;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ext(input logic en, input logic [AW-1:0] addr, input logic data);
    ext_write_enable = en;
    ext_write_addr   = addr;
    ext_write_data   = data;
  endtask

  initial begin
    int n;
    int bad;
    rst_n = 1'b0; swap = 1'b0; read_addr = '0; logic_ready = 1'b1;
    set_ext(1'b0, 9'd0, 1'b0);
    text_list = '{7'h78, 7'h2A, 7'h41, 7'h42, 7'h43, 7'h44, 7'h00, 7'h00};
    text_n = 0; text_rst = 1'b1; mon_clr = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {visible_iter_en, symbol_drawer_start, logic_start, frame_done,
                            read_data, symbol_drawer_x, symbol_drawer_y}, 32'd0);
    check("reset_front_sel", dut.front_sel_r, 32'd0);

    // Frame 1: empty text row, plot logic idle.
    text_rst = 1'b0; mon_clr = 1'b0; rst_n = 1'b1;
    n = 0;
    while (visible_iter_en !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check("f1_release_to_first_iter", n, P + 4);
    while (frame_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check("f1_release_to_frame_done", n, P + 9);
    check("f1_sym_starts", n_sym, 0);
    check("f1_logic_starts", n_logic, 1);
    check("f1_iters", n_iter, 1);

    // Seed back bank with pixels the next fill of this bank must clear.
    set_ext(1'b1, 9'd300, 1'b1); @(negedge clk);
    set_ext(1'b1, 9'd511, 1'b1); @(negedge clk);
    set_ext(1'b0, 9'd0, 1'b0);
    text_n = 2; text_rst = 1'b1; mon_clr = 1'b1; logic_ready = 1'b0; swap = 1'b1;
    @(negedge clk);
    swap = 1'b0; text_rst = 1'b0; mon_clr = 1'b0; read_addr = 9'd300;
    @(negedge clk);
    check("f2_front_300", read_data, 32'd1);
    read_addr = 9'd511;
    @(negedge clk);
    check("f2_front_511", read_data, 32'd1);

    // Frame 2: two symbols, plot logic stalls.
    n = 0;
    while (n_logic == 0 && n < 2000) begin @(negedge clk); n++; end
    check("f2_logic_starts", n_logic, 1);
    check("f2_iters", n_iter, 3);
    check("f2_sym_starts", n_sym, 2);
    check("f2_sym0_x", xs[0], 32'd0);
    check("f2_sym0_y", ys[0], 32'd0);
    check("f2_sym1_x", xs[1], 32'd16);
    check("f2_sym1_y", ys[1], 32'd0);
    read_addr = 9'd197; bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 10) set_ext(1'b1, 9'd197, 1'b1);
      else set_ext(1'b0, 9'd0, 1'b0);
      @(negedge clk);
      if (frame_done !== 1'b0) bad++;
    end
    check("f2_frame_done_low_while_logic_busy", bad, 0);
    check("f2_front_197_before_swap", read_data, 32'd0);
    logic_ready = 1'b1;
    n = 0;
    while (frame_done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("f2_done_latency", n, 1);

    // Frame 3: six symbols saturate the 4-cell row.
    text_n = 6; text_rst = 1'b1; mon_clr = 1'b1; swap = 1'b1;
    @(negedge clk);
    swap = 1'b0; text_rst = 1'b0; mon_clr = 1'b0;
    check("swap_edge_reads_old_front", read_data, 32'd0);
    @(negedge clk);
    check("post_swap_front_197", read_data, 32'd1);
    bad = 0; n = 0;
    while (frame_done !== 1'b1 && n < 3000) begin
      @(negedge clk); n++;
      if (read_data !== 1'b1) bad++;
    end
    check("f3_front_kept_through_fill", bad, 0);
    check("f3_frame_done", frame_done, 32'd1);
    check("f3_iters", n_iter, 7);
    check("f3_sym_starts", n_sym, 4);
    check("f3_sym2_x", xs[2], 32'd32);
    check("f3_sym3_x_saturated", xs[3], 32'd48);
    check("f3_logic_starts", n_logic, 1);

    set_ext(1'b1, 9'd50, 1'b1); @(negedge clk);
    set_ext(1'b0, 9'd0, 1'b0);
    text_n = 0; text_rst = 1'b1; read_addr = 9'd300; swap = 1'b1;
    @(negedge clk);
    swap = 1'b0; text_rst = 1'b0;
    @(negedge clk);
    check("f4_front_300_cleared", read_data, 32'd0);
    read_addr = 9'd511;
    @(negedge clk);
    check("f4_front_511_cleared", read_data, 32'd0);
    read_addr = 9'd50;
    @(negedge clk);
    check("f4_front_50", read_data, 32'd1);
    check("front_sel_after_three_swaps", dut.front_sel_r, 32'd1);

    // Asynchronous reset in the middle of the frame-4 fill.
    repeat (30) @(negedge clk);
    check("pre_reset_read", read_data, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {visible_iter_en, symbol_drawer_start, logic_start, frame_done,
                                  read_data, symbol_drawer_x, symbol_drawer_y}, 32'd0);
    check("async_reset_front_sel", dut.front_sel_r, 32'd0);
    @(negedge clk);
    text_rst = 1'b1; mon_clr = 1'b1;
    @(negedge clk);
    text_rst = 1'b0; mon_clr = 1'b0; rst_n = 1'b1;
    n = 0;
    while (visible_iter_en !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check("restart_release_to_first_iter", n, P + 4);
    check("pulse_widths", n_wide, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
